// File: rtl/ysyx_22050078_ifu_pkg.sv
// rtl/ysyx_22050078_ifu_pkg.sv - shared types and constants for the instruction fetch unit
package ysyx_22050078_ifu_pkg;

  localparam int INST_WIDTH      = 32;
  localparam int IFU_STATE_WIDTH = 2;

  typedef enum logic [IFU_STATE_WIDTH-1:0] {
    IFU_IDLE = 2'd0,
    IFU_REQ  = 2'd1,
    IFU_WAIT = 2'd2,
    IFU_HOLD = 2'd3
  } ifu_state_e;

endpackage

// File: rtl/ysyx_22050078_ifu.sv
// rtl/ysyx_22050078_ifu.sv - instruction fetch unit: PC owner, single outstanding fetch, registered hand-off to decode
module ysyx_22050078_ifu
  import ysyx_22050078_ifu_pkg::*;
#(
  parameter int                  PC_WIDTH = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(64'h8000_0000)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  o_imem_req,
  output logic [PC_WIDTH-1:0]   o_imem_addr,
  input  logic                  i_imem_gnt,
  input  logic                  i_imem_rvalid,
  input  logic [INST_WIDTH-1:0] i_imem_rdata,
  output logic [INST_WIDTH-1:0] o_inst,
  output logic [PC_WIDTH-1:0]   o_pc,
  output logic                  o_inst_valid,
  input  logic                  i_idu_ready,
  input  logic                  i_redirect,
  input  logic [PC_WIDTH-1:0]   i_redirect_pc,
  output logic [1:0]            s_if_err,
  output logic [63:0]           s_fetch_cnt
);

  ifu_state_e            r_state;
  ifu_state_e            w_state_nxt;
  logic [PC_WIDTH-1:0]   r_pc;
  logic [PC_WIDTH-1:0]   w_pc_nxt;
  logic                  r_drop;
  logic                  w_drop_nxt;
  logic                  w_valid_nxt;
  logic                  w_capture;
  logic                  w_count;
  logic [INST_WIDTH-1:0] r_inst;
  logic [PC_WIDTH-1:0]   r_pc_out;
  logic                  r_valid;
  logic [1:0]            r_err;
  logic [63:0]           r_cnt;

  // Memory-side outputs come only from registered state so no input reaches them combinationally.
  assign o_imem_req   = (r_state == IFU_REQ);
  assign o_imem_addr  = r_pc;
  assign o_inst       = r_inst;
  assign o_pc         = r_pc_out;
  assign o_inst_valid = r_valid;
  assign s_if_err     = r_err;
  assign s_fetch_cnt  = r_cnt;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_drop_nxt  = r_drop;
    w_valid_nxt = r_valid;
    w_capture   = 1'b0;
    w_count     = 1'b0;

    case (r_state)
      IFU_IDLE: w_state_nxt = IFU_REQ;
      IFU_REQ: begin
        if (i_imem_gnt) w_state_nxt = IFU_WAIT;
      end
      IFU_WAIT: begin
        if (i_imem_rvalid) begin
          if (r_drop) begin
            w_drop_nxt  = 1'b0;
            w_state_nxt = IFU_REQ;
          end else begin
            w_capture   = 1'b1;
            w_valid_nxt = 1'b1;
            w_state_nxt = IFU_HOLD;
          end
        end
      end
      IFU_HOLD: begin
        if (i_idu_ready) begin
          w_valid_nxt = 1'b0;
          w_pc_nxt    = r_pc + PC_WIDTH'(4);
          w_count     = 1'b1;
          w_state_nxt = IFU_REQ;
        end
      end
      default: w_state_nxt = IFU_IDLE;
    endcase

    // Redirect overrides everything; a fetch already accepted by memory must have its response swallowed.
    if (i_redirect) begin
      w_pc_nxt = {i_redirect_pc[PC_WIDTH-1:2], 2'b00};
      case (r_state)
        IFU_REQ: begin
          if (i_imem_gnt) begin
            w_drop_nxt  = 1'b1;
            w_state_nxt = IFU_WAIT;
          end else begin
            w_state_nxt = IFU_REQ;
          end
        end
        IFU_WAIT: begin
          if (i_imem_rvalid) begin
            w_capture   = 1'b0;
            w_valid_nxt = 1'b0;
            w_drop_nxt  = 1'b0;
            w_state_nxt = IFU_REQ;
          end else begin
            w_drop_nxt  = 1'b1;
            w_state_nxt = IFU_WAIT;
          end
        end
        IFU_HOLD: begin
          w_valid_nxt = 1'b0;
          w_count     = 1'b0;
          w_state_nxt = IFU_REQ;
        end
        default: w_state_nxt = IFU_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IFU_IDLE;
      r_pc     <= RESET_PC;
      r_drop   <= 1'b0;
      r_inst   <= '0;
      r_pc_out <= '0;
      r_valid  <= 1'b0;
      r_err    <= 2'b00;
      r_cnt    <= 64'd0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_drop  <= w_drop_nxt;
      r_valid <= w_valid_nxt;
      if (w_capture) begin
        r_inst   <= i_imem_rdata;
        r_pc_out <= r_pc;
      end
      if (w_count) r_cnt <= r_cnt + 64'd1;
      if (i_redirect && (i_redirect_pc[1:0] != 2'b00)) r_err[0] <= 1'b1;
      if (i_imem_rvalid && (r_state != IFU_WAIT)) r_err[1] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ysyx_22050078_ifu.sv
// tb/tb_ysyx_22050078_ifu.sv - directed self-checking bench for the instruction fetch unit
module tb_ysyx_22050078_ifu;

  logic        clk;
  logic        rst_n;
  logic        o_imem_req;
  logic [63:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic [31:0] o_inst;
  logic [63:0] o_pc;
  logic        o_inst_valid;
  logic        i_idu_ready;
  logic        i_redirect;
  logic [63:0] i_redirect_pc;
  logic [1:0]  s_if_err;
  logic [63:0] s_fetch_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  ysyx_22050078_ifu dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_gnt    (i_imem_gnt),
    .i_imem_rvalid (i_imem_rvalid),
    .i_imem_rdata  (i_imem_rdata),
    .o_inst        (o_inst),
    .o_pc          (o_pc),
    .o_inst_valid  (o_inst_valid),
    .i_idu_ready   (i_idu_ready),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .s_if_err      (s_if_err),
    .s_fetch_cnt   (s_fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Zero-wait fetch from REQ with decode ready; ends back in REQ at addr+4.
  task automatic fetch_zw(input logic [63:0] addr, input logic [31:0] data, input logic [63:0] cnt_after);
    chk("fz_req", {63'd0, o_imem_req}, 64'd1);
    chk("fz_addr", o_imem_addr, addr);
    i_imem_gnt = 1'b1;
    step();
    i_imem_gnt = 1'b0;
    chk("fz_wait_noreq", {63'd0, o_imem_req}, 64'd0);
    i_imem_rvalid = 1'b1;
    i_imem_rdata  = data;
    step();
    i_imem_rvalid = 1'b0;
    chk("fz_valid", {63'd0, o_inst_valid}, 64'd1);
    chk("fz_inst", {32'd0, o_inst}, {32'd0, data});
    chk("fz_pc", o_pc, addr);
    step();
    chk("fz_valid_clr", {63'd0, o_inst_valid}, 64'd0);
    chk("fz_next_req", {63'd0, o_imem_req}, 64'd1);
    chk("fz_next_addr", o_imem_addr, addr + 64'd4);
    chk("fz_cnt", s_fetch_cnt, cnt_after);
  endtask

  initial begin
    rst_n         = 1'b0;
    i_imem_gnt    = 1'b0;
    i_imem_rvalid = 1'b0;
    i_imem_rdata  = 32'd0;
    i_idu_ready   = 1'b1;
    i_redirect    = 1'b0;
    i_redirect_pc = 64'd0;
    step();
    step();
    chk("rst_req", {63'd0, o_imem_req}, 64'd0);
    chk("rst_addr", o_imem_addr, 64'h8000_0000);
    chk("rst_inst", {32'd0, o_inst}, 64'd0);
    chk("rst_pc", o_pc, 64'd0);
    chk("rst_valid", {63'd0, o_inst_valid}, 64'd0);
    chk("rst_err", {62'd0, s_if_err}, 64'd0);
    chk("rst_cnt", s_fetch_cnt, 64'd0);
    rst_n = 1'b1;
    chk("idle_noreq", {63'd0, o_imem_req}, 64'd0);
    step();

    // Back-to-back zero-wait fetches, one instruction per three cycles.
    fetch_zw(64'h8000_0000, 32'h0000_0013, 64'd1);
    fetch_zw(64'h8000_0004, 32'h0000_0013, 64'd2);
    fetch_zw(64'h8000_0008, 32'h0000_0013, 64'd3);

    // Decode stalls five cycles in HOLD.
    i_idu_ready = 1'b0;
    i_imem_gnt  = 1'b1;
    step();
    i_imem_gnt    = 1'b0;
    i_imem_rvalid = 1'b1;
    i_imem_rdata  = 32'h0010_0093;
    step();
    i_imem_rvalid = 1'b0;
    i_imem_rdata  = 32'h0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {63'd0, o_inst_valid}, 64'd1);
      chk("stall_inst", {32'd0, o_inst}, 64'h0010_0093);
      chk("stall_pc", o_pc, 64'h8000_000C);
      chk("stall_noreq", {63'd0, o_imem_req}, 64'd0);
      step();
    end
    i_idu_ready = 1'b1;
    step();
    chk("stall_rel_req", {63'd0, o_imem_req}, 64'd1);
    chk("stall_rel_addr", o_imem_addr, 64'h8000_0010);
    chk("stall_rel_cnt", s_fetch_cnt, 64'd4);

    // Redirect in the same cycle as grant: that response is dropped.
    i_imem_gnt    = 1'b1;
    i_redirect    = 1'b1;
    i_redirect_pc = 64'h8000_1000;
    step();
    i_imem_gnt = 1'b0;
    i_redirect = 1'b0;
    chk("drop_wait_noreq", {63'd0, o_imem_req}, 64'd0);
    i_imem_rvalid = 1'b1;
    i_imem_rdata  = 32'hDEAD_BEEF;
    step();
    i_imem_rvalid = 1'b0;
    chk("drop_novalid", {63'd0, o_inst_valid}, 64'd0);
    chk("drop_err", {62'd0, s_if_err}, 64'd0);
    fetch_zw(64'h8000_1000, 32'h0000_0513, 64'd5);

    // Misaligned redirect in HOLD while decode is ready: not counted.
    i_imem_gnt = 1'b1;
    step();
    i_imem_gnt    = 1'b0;
    i_imem_rvalid = 1'b1;
    i_imem_rdata  = 32'h0000_0593;
    step();
    i_imem_rvalid = 1'b0;
    chk("hold_valid", {63'd0, o_inst_valid}, 64'd1);
    i_redirect    = 1'b1;
    i_redirect_pc = 64'h8000_0102;
    step();
    i_redirect = 1'b0;
    chk("rdh_valid", {63'd0, o_inst_valid}, 64'd0);
    chk("rdh_cnt", s_fetch_cnt, 64'd5);
    chk("rdh_err", {62'd0, s_if_err}, 64'd1);
    chk("rdh_req", {63'd0, o_imem_req}, 64'd1);
    chk("rdh_addr", o_imem_addr, 64'h8000_0100);

    // Grant delayed four cycles, response delayed three.
    for (int i = 0; i < 4; i++) begin
      chk("slow_req", {63'd0, o_imem_req}, 64'd1);
      chk("slow_addr", o_imem_addr, 64'h8000_0100);
      step();
    end
    i_imem_gnt = 1'b1;
    step();
    i_imem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("slow_wait_noreq", {63'd0, o_imem_req}, 64'd0);
      chk("slow_wait_novalid", {63'd0, o_inst_valid}, 64'd0);
      step();
    end
    i_imem_rvalid = 1'b1;
    i_imem_rdata  = 32'h0040_0613;
    step();
    i_imem_rvalid = 1'b0;
    chk("slow_valid", {63'd0, o_inst_valid}, 64'd1);
    chk("slow_inst", {32'd0, o_inst}, 64'h0040_0613);
    chk("slow_pc", o_pc, 64'h8000_0100);
    step();
    chk("slow_cnt", s_fetch_cnt, 64'd6);
    chk("slow_next_addr", o_imem_addr, 64'h8000_0104);

    // Response with nothing outstanding is flagged and ignored.
    i_imem_rvalid = 1'b1;
    i_imem_rdata  = 32'hFFFF_FFFF;
    step();
    i_imem_rvalid = 1'b0;
    chk("spur_err", {62'd0, s_if_err}, 64'd3);
    chk("spur_novalid", {63'd0, o_inst_valid}, 64'd0);
    chk("spur_req", {63'd0, o_imem_req}, 64'd1);

    // PC wraps past the top of the address space.
    i_redirect    = 1'b1;
    i_redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    i_redirect = 1'b0;
    fetch_zw(64'hFFFF_FFFF_FFFF_FFFC, 32'h0000_0073, 64'd7);

    // Asynchronous reset while waiting for a response.
    i_imem_gnt = 1'b1;
    step();
    i_imem_gnt = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_req", {63'd0, o_imem_req}, 64'd0);
    chk("arst_addr", o_imem_addr, 64'h8000_0000);
    chk("arst_inst", {32'd0, o_inst}, 64'd0);
    chk("arst_pc", o_pc, 64'd0);
    chk("arst_valid", {63'd0, o_inst_valid}, 64'd0);
    chk("arst_err", {62'd0, s_if_err}, 64'd0);
    chk("arst_cnt", s_fetch_cnt, 64'd0);
    step();
    rst_n = 1'b1;
    chk("arst_idle", {63'd0, o_imem_req}, 64'd0);
    step();
    chk("arst_first_req", {63'd0, o_imem_req}, 64'd1);
    chk("arst_first_addr", o_imem_addr, 64'h8000_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
